// File: rtl/uart_result_tx.sv
// rtl/uart_result_tx.sv - serializes a result word over UART 8N1, MSB byte first (ASCII hex mode: UART_RESULT_TX_ASCII_HEX_EN)
module uart_result_tx #(
  parameter int WIDTH_DIN    = 128,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH_DIN-1:0] din,
  input  logic                 din_valid,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam int NBYTES = WIDTH_DIN / 8;
`ifdef UART_RESULT_TX_ASCII_HEX_EN
  // One character per nibble, then CR and LF.
  localparam int NFRAMES = 2 * NBYTES + 2;
  localparam int SHIFT   = 4;
`else
  localparam int NFRAMES = NBYTES;
  localparam int SHIFT   = 8;
`endif
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int FW = (NFRAMES > 1) ? $clog2(NFRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX    = CW'(CLKS_PER_BIT - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(NFRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t               state_q;
  logic                 din_valid_q;
  logic [CW-1:0]        cnt_q;
  logic [2:0]           bit_q;
  logic [FW-1:0]        frame_q;
  logic [WIDTH_DIN-1:0] hold_q;
  logic [7:0]           data_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 overrun_q;

  logic                 rise_d;
  logic [7:0]           frame_byte_d;

  // Rising edge of din_valid: a held level produces a single transfer.
  assign rise_d = din_valid & ~din_valid_q;

`ifdef UART_RESULT_TX_ASCII_HEX_EN
  logic [3:0] nib_d;
  // Character for the current frame: top nibble of the hold register as hex, or the CR/LF trailer.
  always_comb begin
    nib_d = hold_q[WIDTH_DIN-1 -: 4];
    if (frame_q == FW'(NFRAMES - 2))
      frame_byte_d = 8'h0D;
    else if (frame_q == LAST_FRAME)
      frame_byte_d = 8'h0A;
    else if (nib_d < 4'd10)
      frame_byte_d = 8'h30 + {4'd0, nib_d};
    else
      frame_byte_d = 8'h37 + {4'd0, nib_d};
  end
`else
  // Byte for the current frame: the hold register shifts left so its top byte is always next.
  always_comb begin
    frame_byte_d = hold_q[WIDTH_DIN-1 -: 8];
  end
`endif

  // Frame sequencer: start bit, 8 data bits LSB first, stop bit; frames run back to back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      din_valid_q <= 1'b0;
      cnt_q       <= '0;
      bit_q       <= '0;
      frame_q     <= '0;
      hold_q      <= '0;
      data_q      <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      din_valid_q <= din_valid;
      done_q      <= 1'b0;
      if (rise_d && busy_q)
        overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (rise_d) begin
            hold_q  <= din;
            frame_q <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= frame_byte_d[0];
            data_q  <= {1'b0, frame_byte_d[7:1]};
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_q  <= bit_q + 1'b1;
              tx_q   <= data_q[0];
              data_q <= {1'b0, data_q[7:1]};
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
            if (frame_q == LAST_FRAME) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              frame_q <= frame_q + 1'b1;
              hold_q  <= hold_q << SHIFT;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: doc/uart_result_tx.md
Name: uart_result_tx

Overview:
- Return path of the UART coprocessor. Takes the 128-bit result word and its valid signal from the coprocessor, then serializes the word back to the host over UART 8N1.
- Sits between the coprocessor output (dout/dout_valid) and the board TX pin.
- Provides one frame sequence per result, with busy, done and overrun status for control/debug.

Parameters:
- WIDTH_DIN, 128, result word width in bits; must be a multiple of 8; NBYTES = WIDTH_DIN/8.
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- din  input  WIDTH_DIN  result word; sampled only on the capture cycle.
- din_valid  input  1  result valid; level or pulse; rising edge triggers capture.
- tx  output  1  UART serial out, idle high, registered.
- busy  output  1  high from the cycle after capture until the last stop bit completes.
- done  output  1  one-cycle pulse at the end of the final stop bit.
- overrun  output  1  sticky; set when a rising edge of din_valid arrives while busy; cleared only by rst.

Behaviour:
- Reset values: tx=1, busy=0, done=0, overrun=0; internal din_valid_q=0, FSM=IDLE, counters=0.
- Edge detect: rise = din_valid & ~din_valid_q, with din_valid_q registered every cycle. Upstream holds valid high for many cycles, so a held level yields exactly one transfer.
- Capture: in IDLE, on rise, din is latched into a shift/hold register and the FSM goes to START.
  - busy=1 and tx=0 from the next cycle (latency 1 from the capture cycle).
- FSM states:
  - IDLE: tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If the byte index is below NBYTES-1: increment the index and go to START. There is no idle gap between bytes.
    - Else: go to IDLE with busy=0 and done=1 in the same cycle.
- Byte order: most significant byte first (din[WIDTH_DIN-1 -: 8] is frame 0); least significant byte last.
- Total transfer: 10*CLKS_PER_BIT*NBYTES cycles from the first start-bit cycle to done.
- Counters:
  - Bit-time counter runs 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
  - Bit index runs 0..7; byte index runs 0..NBYTES-1.
  - All counter widths are sized with $clog2.
- Rise while busy:
  - Ignored; the captured word is unaffected.
  - overrun is set the next cycle.
- Rise in the done cycle: the FSM is already IDLE-eligible, so the rise is accepted as a new capture and is not an overrun. busy is 0 for that one cycle only, then re-asserts.
- din changing after capture has no effect on the transfer in progress.
- rst mid-transfer aborts immediately:
  - Next cycle: tx=1, busy=0, done=0, overrun=0, FSM=IDLE.
  - The partial frame is discarded. No stop bit is completed beyond line-high.
- rst asserted with din_valid high: din_valid_q resets to 0. If din_valid is still high after rst deasserts, that counts as a rise and triggers capture.

Optional Feature:
- Macro: UART_RESULT_TX_ASCII_HEX_EN.
- Defined: the word is sent as uppercase ASCII hex.
  - 2*NBYTES characters, most significant nibble first ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46).
  - Followed by CR (0x0D) and LF (0x0A); total 2*NBYTES+2 frames.
  - done pulses after the LF stop bit.
- Not defined: raw binary, NBYTES frames, as described above.
- All other rules (edge detect, overrun, reset, timing per frame) are identical in both modes.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and WIDTH_DIN=128.
- Reset: hold rst 3 cycles with din_valid=0 -> tx=1, busy=0, done=0, overrun=0 throughout and after release.
- Single pulse: din=128'h0102030405060708090A0B0C0D0E0F10, din_valid high 1 cycle -> tx low on capture+1. Decoded frames are 0x01..0x10 in order. done pulses exactly 640 cycles after the first start bit; busy falls in the same cycle.
- Held level: din_valid high for 2000 cycles with the same din -> exactly 16 frames, one done, overrun=0.
- Overrun: second rise during frame 5 with din=all-ones -> overrun=1 next cycle. All 16 frames still match the first word; overrun stays 1 until rst.
- Abort and back-to-back:
  - rst during bit 3 of frame 2 -> tx=1 and busy=0 next cycle.
  - Then a pulse with din=128'hFF followed by a rise in the done cycle -> the second word is accepted with no overrun. Its frames follow after 1 idle cycle: 15x 0x00 then 0xFF.
- ASCII mode (macro defined): din=128'hDEADBEEF -> 34 frames: "000000000000000000000000DEADBEEF" then 0x0D, 0x0A. done occurs after 1360 cycles.
